// File: rtl/alarm_speaker_arbiter.sv
// rtl/alarm_speaker_arbiter.sv - speaker arbiter for four alarms and an hourly chime
// Optional snooze re-arm counters are built only when ALARM_SNOOZE_EN is defined.
module alarm_speaker_arbiter #(
   parameter int CHIME_SECS  = 2,
   parameter int SNOOZE_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_tick,
   input  logic [3:0] alr_req,
   input  logic [7:0] alr_len,
   input  logic [7:0] alr_music,
   input  logic       chime_req,
   input  logic       dismiss,
   input  logic       snooze,
   output logic [3:0] alr_grant,
   output logic       chime_grant,
   output logic       spk_en,
   output logic [1:0] song_sel,
   output logic [5:0] remain_sec
);

   typedef enum logic [1:0] {IDLE, PLAY_ALR, PLAY_CHIME, GAP} state_t;

   state_t     state;
   logic [3:0] alr_prev;
   logic       chime_prev;
   logic [3:0] pending;
   logic       chime_pend;
   logic [1:0] gidx;

   logic [3:0] alr_rise;
   logic       chime_rise;
   logic [3:0] snz_fire;
   logic [3:0] pend_clr;
   logic       chime_clr;
   logic [3:0] pending_nxt;
   logic       chime_nxt;
   logic [1:0] pick_idx;
   logic       any_pend;
   logic       tick_end;
   logic       alr_stop;
   logic       chime_stop;

   function automatic logic [5:0] len_secs(input logic [1:0] code);
      case (code)
         2'd0:    len_secs = 6'd15;
         2'd1:    len_secs = 6'd30;
         2'd2:    len_secs = 6'd45;
         default: len_secs = 6'd60;
      endcase
   endfunction

   assign alr_rise   = alr_req & ~alr_prev;
   assign chime_rise = chime_req & ~chime_prev;
   assign tick_end   = sec_tick && (remain_sec == 6'd1);
   assign spk_en     = (|alr_grant) | chime_grant;

`ifdef ALARM_SNOOZE_EN
   logic [7:0] snooze_cnt [4];
   logic       snz_load;

   // dismiss has priority: a simultaneous snooze never arms a counter
   assign snz_load   = (state == PLAY_ALR) && snooze && !dismiss;
   assign alr_stop   = dismiss || snooze || tick_end;
   assign chime_stop = dismiss || snooze || tick_end || (|alr_rise);

   always_comb begin
      snz_fire = '0;
      for (int i = 0; i < 4; i++) begin
         snz_fire[i] = sec_tick && (snooze_cnt[i] == 8'd1) && !(snz_load && gidx == 2'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) snooze_cnt[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (snz_load && gidx == 2'(i))
               snooze_cnt[i] <= 8'(SNOOZE_SECS);
            else if (sec_tick && snooze_cnt[i] != 8'd0)
               snooze_cnt[i] <= snooze_cnt[i] - 8'd1;
         end
      end
   end
`else
   logic unused_snooze;

   assign unused_snooze = snooze;
   assign snz_fire      = 4'b0000;
   assign alr_stop      = dismiss || tick_end;
   assign chime_stop    = dismiss || tick_end || (|alr_rise);
`endif

   always_comb begin
      pick_idx = 2'd0;
      any_pend = |pending;
      for (int i = 3; i >= 0; i--) begin
         if (pending[i]) pick_idx = 2'(i);
      end
   end

   // a set arriving in the same cycle as the grant-clear survives
   always_comb begin
      pend_clr  = '0;
      chime_clr = 1'b0;
      if (state == IDLE) begin
         if (any_pend) pend_clr[pick_idx] = 1'b1;
         else if (chime_pend) chime_clr = 1'b1;
      end
      pending_nxt = (pending & ~pend_clr) | alr_rise | snz_fire;
      chime_nxt   = (chime_pend & ~chime_clr) | (chime_rise && state != PLAY_ALR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         alr_prev    <= '0;
         chime_prev  <= 1'b0;
         pending     <= '0;
         chime_pend  <= 1'b0;
         gidx        <= 2'd0;
         alr_grant   <= '0;
         chime_grant <= 1'b0;
         song_sel    <= 2'd0;
         remain_sec  <= 6'd0;
      end else begin
         alr_prev   <= alr_req;
         chime_prev <= chime_req;
         pending    <= pending_nxt;
         chime_pend <= chime_nxt;
         case (state)
            IDLE: begin
               if (any_pend) begin
                  state      <= PLAY_ALR;
                  gidx       <= pick_idx;
                  alr_grant  <= 4'b0001 << pick_idx;
                  song_sel   <= alr_music[{pick_idx, 1'b0} +: 2];
                  remain_sec <= len_secs(alr_len[{pick_idx, 1'b0} +: 2]);
               end else if (chime_pend) begin
                  state       <= PLAY_CHIME;
                  chime_grant <= 1'b1;
                  song_sel    <= 2'b11;
                  remain_sec  <= 6'(CHIME_SECS);
               end
            end
            PLAY_ALR, PLAY_CHIME: begin
               if ((state == PLAY_ALR) ? alr_stop : chime_stop) begin
                  state       <= GAP;
                  alr_grant   <= '0;
                  chime_grant <= 1'b0;
                  song_sel    <= 2'd0;
                  remain_sec  <= 6'd0;
               end else if (sec_tick) begin
                  remain_sec <= remain_sec - 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_speaker_arbiter.sv
// tb/tb_alarm_speaker_arbiter.sv - directed bench with grant scoreboard for alarm_speaker_arbiter
module tb_alarm_speaker_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       sec_tick;
   logic [3:0] alr_req;
   logic [7:0] alr_len;
   logic [7:0] alr_music;
   logic       chime_req;
   logic       dismiss;
   logic       snooze;
   logic [3:0] alr_grant;
   logic       chime_grant;
   logic       spk_en;
   logic [1:0] song_sel;
   logic [5:0] remain_sec;

   int checks = 0;
   int errors = 0;
   logic [12:0] exp_q[$];
   logic        prev_spk = 1'b0;

   alarm_speaker_arbiter #(.CHIME_SECS(2), .SNOOZE_SECS(3)) dut (
      .clk(clk), .rst(rst), .sec_tick(sec_tick), .alr_req(alr_req),
      .alr_len(alr_len), .alr_music(alr_music), .chime_req(chime_req),
      .dismiss(dismiss), .snooze(snooze), .alr_grant(alr_grant),
      .chime_grant(chime_grant), .spk_en(spk_en), .song_sel(song_sel),
      .remain_sec(remain_sec)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] word();
      return {alr_grant, chime_grant, song_sel, remain_sec};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         sec_tick = 1'b1;
         step(1);
         sec_tick = 1'b0;
      end
   endtask

   task automatic pulse_dismiss();
      dismiss = 1'b1;
      step(1);
      dismiss = 1'b0;
   endtask

   // each new grant start is checked against the next queued expectation
   always @(negedge clk) begin
      if (spk_en && !prev_spk) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected_grant: observed %0h expected none", word());
         end else begin
            chk("sb_grant", 32'(word()), 32'(exp_q.pop_front()));
         end
      end
      prev_spk = spk_en;
   end

   initial begin
      rst = 1'b1; sec_tick = 1'b0; alr_req = '0; alr_len = 8'h00;
      alr_music = {2'd0, 2'd2, 2'd1, 2'd0};
      chime_req = 1'b0; dismiss = 1'b0; snooze = 1'b0;
      step(3);
      chk("reset_word", 32'(word()), 0);
      chk("reset_spk", 32'(spk_en), 0);
      rst = 1'b0;
      step(2);

      // single alarm, 15 s
      alr_req[2] = 1'b1;
      exp_q.push_back({4'b0100, 1'b0, 2'd2, 6'd15});
      step(1);
      chk("a2_not_yet", 32'(alr_grant), 0);
      step(1);
      chk("a2_grant", 32'(alr_grant), 32'b0100);
      chk("a2_remain", 32'(remain_sec), 15);
      alr_req[2] = 1'b0;
      tick_n(14);
      chk("a2_remain_last", 32'(remain_sec), 1);
      chk("a2_still_on", 32'(spk_en), 1);
      tick_n(1);
      chk("a2_gap_spk", 32'(spk_en), 0);
      chk("a2_gap_remain", 32'(remain_sec), 0);
      step(1);
      chk("a2_idle_spk", 32'(spk_en), 0);
      step(2);

      // simultaneous alarms 0 and 3
      alr_req = 4'b1001;
      exp_q.push_back({4'b0001, 1'b0, 2'd0, 6'd15});
      exp_q.push_back({4'b1000, 1'b0, 2'd0, 6'd15});
      step(2);
      chk("a0_first", 32'(alr_grant), 32'b0001);
      tick_n(15);
      chk("a0_gap", 32'(spk_en), 0);
      step(1);
      chk("a0_idle", 32'(spk_en), 0);
      step(1);
      chk("a3_second", 32'(alr_grant), 32'b1000);
      tick_n(15);
      alr_req = 4'b0000;
      step(3);
      chk("a3_done", 32'(spk_en), 0);

      // chime aborted by alarm 1
      chime_req = 1'b1;
      exp_q.push_back({4'b0000, 1'b1, 2'd3, 6'd2});
      step(2);
      chk("chime_grant", 32'(chime_grant), 1);
      chk("chime_song", 32'(song_sel), 3);
      tick_n(1);
      chk("chime_remain", 32'(remain_sec), 1);
      alr_req[1] = 1'b1;
      exp_q.push_back({4'b0010, 1'b0, 2'd1, 6'd15});
      step(1);
      chk("chime_abort_gap", 32'(spk_en), 0);
      step(2);
      chk("a1_after_chime", 32'(alr_grant), 32'b0010);
      pulse_dismiss();
      step(4);
      chk("chime_no_resume", 32'(chime_grant), 0);
      chk("chime_no_resume_spk", 32'(spk_en), 0);
      alr_req = 4'b0000; chime_req = 1'b0;
      step(2);

      // 60 s alarm, chime edge discarded, dismiss
      alr_len = 8'h03;
      alr_req[0] = 1'b1;
      exp_q.push_back({4'b0001, 1'b0, 2'd0, 6'd60});
      step(2);
      chk("a0_len60", 32'(remain_sec), 60);
      chime_req = 1'b1;
      step(1);
      alr_req[0] = 1'b0;
      pulse_dismiss();
      chk("dismiss_gap_spk", 32'(spk_en), 0);
      chk("dismiss_gap_remain", 32'(remain_sec), 0);
      step(4);
      chk("chime_discarded", 32'(spk_en), 0);
      chime_req = 1'b0;
      alr_len = 8'h00;
      step(2);

      // snooze on alarm 1
      alr_req[1] = 1'b1;
      exp_q.push_back({4'b0010, 1'b0, 2'd1, 6'd15});
      step(2);
      chk("snz_a1_grant", 32'(alr_grant), 32'b0010);
      tick_n(1);
      chk("snz_a1_remain", 32'(remain_sec), 14);
      snooze = 1'b1;
      step(1);
      snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
      chk("snz_gap", 32'(spk_en), 0);
      exp_q.push_back({4'b0010, 1'b0, 2'd1, 6'd15});
      tick_n(2);
      chk("snz_silent", 32'(spk_en), 0);
      tick_n(1);
      chk("snz_silent_last", 32'(spk_en), 0);
      step(1);
      chk("snz_regrant", 32'(alr_grant), 32'b0010);
      chk("snz_regrant_len", 32'(remain_sec), 15);
`else
      chk("snz_ignored_spk", 32'(spk_en), 1);
      chk("snz_ignored_remain", 32'(remain_sec), 14);
`endif
      pulse_dismiss();
      alr_req = 4'b0000;
      step(3);

      // reset mid-grant with request held
      alr_req[2] = 1'b1;
      exp_q.push_back({4'b0100, 1'b0, 2'd2, 6'd15});
      step(2);
      chk("rst_pre_grant", 32'(alr_grant), 32'b0100);
      tick_n(1);
      rst = 1'b1;
      step(1);
      chk("rst_word", 32'(word()), 0);
      chk("rst_spk", 32'(spk_en), 0);
      step(1);
      rst = 1'b0;
      exp_q.push_back({4'b0100, 1'b0, 2'd2, 6'd15});
      step(2);
      chk("rst_regrant", 32'(alr_grant), 32'b0100);
      chk("rst_regrant_len", 32'(remain_sec), 15);
      alr_req = 4'b0000;
      pulse_dismiss();
      step(3);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
